axi_lite_master_sequencer: RTL and testbench
============================================

# axi_lite_master_sequencer

Single-outstanding AXI-Lite master. Accepts one read or write command at a time on a simple command port. Drives the five AXI-Lite channels toward an `axi_lite_slave_interface` instance and returns one response pulse per command. A per-transaction watchdog aborts any transaction that hangs on a slave whose ready/valid timers never fire, so the fabric always recovers.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `TRANS_W_STRB_W`, 4, write-strobe width
- `TRANS_WR_RESP_W`, 2, BRESP/RRESP width
- `TRANS_PROT`, 3, AWPROT/ARPROT width; driven constant 3'b000
- `TIMEOUT_CYCLES`, 64, watchdog limit in clk_i cycles; 0 disables the watchdog
- `clk_i`  in  1  clock, rising edge
- `resetn_i`  in  1  reset, asynchronous, active-low
- `cmd_valid_i` in 1, `cmd_ready_o` out 1 — command handshake
- `cmd_we_i` in 1, `cmd_addr_i` in ADDR_WIDTH, `cmd_wdata_i` in DATA_WIDTH, `cmd_wstrb_i` in TRANS_W_STRB_W — command payload; `cmd_we_i`=1 selects write
- `rsp_valid_o` out 1, `rsp_data_o` out DATA_WIDTH, `rsp_resp_o` out TRANS_WR_RESP_W, `rsp_timeout_o` out 1 — response, single-cycle pulse, no backpressure
- AW channel: `o_axi_awaddr` out ADDR_WIDTH, `o_axi_awprot` out TRANS_PROT, `o_axi_awvalid` out 1, `i_axi_awready` in 1
- W channel: `o_axi_wdata` out DATA_WIDTH, `o_axi_wstrb` out TRANS_W_STRB_W, `o_axi_wvalid` out 1, `i_axi_wready` in 1
- B channel: `i_axi_bresp` in TRANS_WR_RESP_W, `i_axi_bvalid` in 1, `o_axi_bready` out 1
- AR channel: `o_axi_araddr` out ADDR_WIDTH, `o_axi_arprot` out TRANS_PROT, `o_axi_arvalid` out 1, `i_axi_arready` in 1
- R channel: `i_axi_rdata` in DATA_WIDTH, `i_axi_rresp` in TRANS_WR_RESP_W, `i_axi_rvalid` in 1, `o_axi_rready` out 1

## Operation
- FSM states: IDLE, WR_AW_W, WR_RESP, RD_AR, RD_RESP.
- `cmd_ready_o` is 1 exactly in IDLE. It is combinational from state, so it is 1 during reset.
- IDLE, on `cmd_valid_i && cmd_ready_o`:
  - Register addr/wdata/wstrb into AXI output registers; they hold unchanged until return to IDLE, because the slave samples the address on the falling edge of ready.
  - Go to WR_AW_W if `cmd_we_i`, else RD_AR.
- WR_AW_W:
  - `o_axi_awvalid` and `o_axi_wvalid` are asserted together.
  - Each valid drops independently after its own valid&&ready edge; per-channel done flags track this.
  - When both are done, go to WR_RESP. AW and W may complete in either order or in the same cycle.
- WR_RESP: `o_axi_bready`=1 for the whole state, before bvalid, as the slave requires. On bvalid&&bready: latch bresp, go to IDLE.
- RD_AR: `o_axi_arvalid`=1 until arvalid&&arready, then go to RD_RESP.
- RD_RESP: `o_axi_rready`=1. On rvalid&&rready: latch rdata/rresp, go to IDLE.
- Response: on the completing edge, drive `rsp_valid_o`=1 for exactly one cycle. `rsp_data_o` = rdata (0 for writes); `rsp_resp_o` = bresp/rresp; `rsp_timeout_o`=0.
- Watchdog:
  - Counter clears on command acceptance and increments every cycle outside IDLE.
  - When it reaches TIMEOUT_CYCLES, deassert all AXI valids/readys, pulse `rsp_valid_o` with `rsp_timeout_o`=1, `rsp_resp_o`=2'b10 (SLVERR), `rsp_data_o`=0, and go to IDLE.
  - A handshake completing on the same edge as the timeout wins: it is reported as a normal response.
- `cmd_valid_i` outside IDLE is ignored. No command queue.

## Timing
- Reset: state IDLE; every output register is 0, including all AXI valids/readys, `rsp_*`, and addr/data.
- Command accepted at edge N: awvalid/wvalid or arvalid go high in cycle N+1 (registered outputs).
- A valid is low in the cycle after its handshake edge.
- B/R handshake at edge M: `rsp_valid_o` is high in cycle M+1, with state IDLE. A new command can be accepted at edge M+1, so there is zero idle overhead back-to-back.
- Timeout fires at edge N+TIMEOUT_CYCLES.
- Reset asserted mid-transaction: all valids/readys drop asynchronously and no response is emitted.

## Structure
- Shared package/include `axi_lite_pkg` holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - FSM state encodings
  - PROT_DEFAULT=3'b000
- Sub-module `txn_watchdog` (params TIMEOUT_CYCLES; ports clk_i, resetn_i, clear_i, run_i, expired_o) holds the counter of width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, slave CYCLE_CLOCK=3 -> AW/W each handshake once, slave captures 0x10/0xDEADBEEF, `rsp_valid_o` pulse with resp 00, timeout 0.
- Read 0x20, slave returns 0x12345678/OKAY -> `rsp_data_o`=0x12345678, `rsp_resp_o`=00, exactly one pulse.
- Slave model giving awready 2 cycles before wready, then the reverse, then both on the same edge -> WR_RESP entered only after both; each valid low the cycle after its own handshake.
- TIMEOUT_CYCLES=16, awready tied 0 -> at accept+16 all valids 0, `rsp_timeout_o`=1, `rsp_resp_o`=10; next command accepted normally.
- Back-to-back write then read, `cmd_valid_i` held high throughout -> second accept at the same edge as the first `rsp_valid_o`; a `cmd_valid_i` pulse while busy is not accepted.
- Reset asserted in RD_RESP -> arvalid/rready 0 immediately, no `rsp_valid_o`, `cmd_ready_o`=1.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI-Lite master sequencer:
//   - AXI response codes (OKAY / SLVERR)
//   - default AxPROT value
//   - sequencer FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_RESP = 3'd4
    } seq_state_e;

endpackage : axi_lite_pkg

// File: rtl/txn_watchdog.sv
// -----------------------------------------------------------------------------
// txn_watchdog
// Per-transaction cycle counter. Cleared when a command is accepted, counts
// every cycle the sequencer is busy, and flags expiry on the edge that would
// make the count reach TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it.
// Ports:
//   clk_i      clock, rising edge
//   resetn_i   asynchronous active-low reset
//   clear_i    restart the count (command accepted)
//   run_i      sequencer busy (outside IDLE)
//   expired_o  combinational: the current edge is the timeout edge
// -----------------------------------------------------------------------------
module txn_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT_M1 = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_W-1:0] r_count;

    // Busy-cycle counter; saturates at the limit so it can never wrap.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (run_i && (r_count != LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    // Expiry is flagged one count early so the abort lands on accept+TIMEOUT.
    assign expired_o = (TIMEOUT_CYCLES != 0) && run_i && (r_count == LIMIT_M1);

endmodule : txn_watchdog

// File: rtl/axi_lite_master_sequencer.sv
// -----------------------------------------------------------------------------
// axi_lite_master_sequencer
// Single-outstanding AXI-Lite master. Takes one read/write command at a time,
// drives the AW/W/B or AR/R channels, and returns a one-cycle response pulse.
// A watchdog aborts hung transactions with a SLVERR/timeout response.
// Ports:
//   clk_i, resetn_i                 clock / async active-low reset
//   cmd_valid_i, cmd_ready_o        command handshake (ready only in IDLE)
//   cmd_we_i, cmd_addr_i,
//   cmd_wdata_i, cmd_wstrb_i        command payload (we=1 -> write)
//   rsp_valid_o, rsp_data_o,
//   rsp_resp_o, rsp_timeout_o       response pulse, no backpressure
//   o_axi_aw*/i_axi_awready         AW channel
//   o_axi_w*/i_axi_wready           W channel
//   i_axi_b*/o_axi_bready           B channel
//   o_axi_ar*/i_axi_arready         AR channel
//   i_axi_r*/o_axi_rready           R channel
// -----------------------------------------------------------------------------
module axi_lite_master_sequencer
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TRANS_W_STRB_W  = 4,
    parameter int TRANS_WR_RESP_W = 2,
    parameter int TRANS_PROT      = 3,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic                       cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]      cmd_wdata_i,
    input  logic [TRANS_W_STRB_W-1:0]  cmd_wstrb_i,
    output logic                       rsp_valid_o,
    output logic [DATA_WIDTH-1:0]      rsp_data_o,
    output logic [TRANS_WR_RESP_W-1:0] rsp_resp_o,
    output logic                       rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0]      o_axi_awaddr,
    output logic [TRANS_PROT-1:0]      o_axi_awprot,
    output logic                       o_axi_awvalid,
    input  logic                       i_axi_awready,
    output logic [DATA_WIDTH-1:0]      o_axi_wdata,
    output logic [TRANS_W_STRB_W-1:0]  o_axi_wstrb,
    output logic                       o_axi_wvalid,
    input  logic                       i_axi_wready,
    input  logic [TRANS_WR_RESP_W-1:0] i_axi_bresp,
    input  logic                       i_axi_bvalid,
    output logic                       o_axi_bready,
    output logic [ADDR_WIDTH-1:0]      o_axi_araddr,
    output logic [TRANS_PROT-1:0]      o_axi_arprot,
    output logic                       o_axi_arvalid,
    input  logic                       i_axi_arready,
    input  logic [DATA_WIDTH-1:0]      i_axi_rdata,
    input  logic [TRANS_WR_RESP_W-1:0] i_axi_rresp,
    input  logic                       i_axi_rvalid,
    output logic                       o_axi_rready
);

    seq_state_e                 r_state, w_state_nxt;
    logic                       r_awvalid, w_awvalid_nxt;
    logic                       r_wvalid, w_wvalid_nxt;
    logic                       r_aw_done, w_aw_done_nxt;
    logic                       r_w_done, w_w_done_nxt;
    logic                       r_bready, w_bready_nxt;
    logic                       r_arvalid, w_arvalid_nxt;
    logic                       r_rready, w_rready_nxt;
    logic [ADDR_WIDTH-1:0]      r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0]      r_wdata, w_wdata_nxt;
    logic [TRANS_W_STRB_W-1:0]  r_wstrb, w_wstrb_nxt;
    logic                       r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]      r_rsp_data, w_rsp_data_nxt;
    logic [TRANS_WR_RESP_W-1:0] r_rsp_resp, w_rsp_resp_nxt;
    logic                       r_rsp_timeout, w_rsp_timeout_nxt;

    logic w_accept, w_expired, w_abort;
    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    assign cmd_ready_o = (r_state == ST_IDLE);
    assign w_accept    = cmd_valid_i && cmd_ready_o;
    assign w_aw_hs     = r_awvalid && i_axi_awready;
    assign w_w_hs      = r_wvalid && i_axi_wready;
    assign w_b_hs      = r_bready && i_axi_bvalid;
    assign w_ar_hs     = r_arvalid && i_axi_arready;
    assign w_r_hs      = r_rready && i_axi_rvalid;

    txn_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .resetn_i  (resetn_i),
        .clear_i   (w_accept),
        .run_i     (r_state != ST_IDLE),
        .expired_o (w_expired)
    );

    // Next-state and next-output logic; registered values hold unless changed.
    always_comb begin
        w_state_nxt       = r_state;
        w_awvalid_nxt     = r_awvalid;
        w_wvalid_nxt      = r_wvalid;
        w_aw_done_nxt     = r_aw_done;
        w_w_done_nxt      = r_w_done;
        w_bready_nxt      = r_bready;
        w_arvalid_nxt     = r_arvalid;
        w_rready_nxt      = r_rready;
        w_addr_nxt        = r_addr;
        w_wdata_nxt       = r_wdata;
        w_wstrb_nxt       = r_wstrb;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_data_nxt    = r_rsp_data;
        w_rsp_resp_nxt    = r_rsp_resp;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_abort           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Payload is frozen here: the slave samples it late.
                    w_addr_nxt    = cmd_addr_i;
                    w_wdata_nxt   = cmd_wdata_i;
                    w_wstrb_nxt   = cmd_wstrb_i;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    if (cmd_we_i) begin
                        w_state_nxt   = ST_WR_AW_W;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_RD_AR;
                        w_arvalid_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_AW_W: begin
                // Only the final B/R handshake beats the watchdog.
                if (w_expired) begin
                    w_abort = 1'b1;
                end else begin
                    if (w_aw_hs) begin
                        w_awvalid_nxt = 1'b0;
                        w_aw_done_nxt = 1'b1;
                    end else begin
                        w_awvalid_nxt = r_awvalid;
                    end
                    if (w_w_hs) begin
                        w_wvalid_nxt = 1'b0;
                        w_w_done_nxt = 1'b1;
                    end else begin
                        w_wvalid_nxt = r_wvalid;
                    end
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        w_state_nxt  = ST_WR_RESP;
                        w_bready_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_WR_AW_W;
                    end
                end
            end
            ST_WR_RESP: begin
                if (w_b_hs) begin
                    w_state_nxt       = ST_IDLE;
                    w_bready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_data_nxt    = '0;
                    w_rsp_resp_nxt    = i_axi_bresp;
                    w_rsp_timeout_nxt = 1'b0;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end else begin
                    w_state_nxt = ST_WR_RESP;
                end
            end
            ST_RD_AR: begin
                if (w_expired) begin
                    w_abort = 1'b1;
                end else if (w_ar_hs) begin
                    w_state_nxt   = ST_RD_RESP;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_RD_AR;
                end
            end
            ST_RD_RESP: begin
                if (w_r_hs) begin
                    w_state_nxt       = ST_IDLE;
                    w_rready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_data_nxt    = i_axi_rdata;
                    w_rsp_resp_nxt    = i_axi_rresp;
                    w_rsp_timeout_nxt = 1'b0;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end else begin
                    w_state_nxt = ST_RD_RESP;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_awvalid_nxt = 1'b0;
                w_wvalid_nxt  = 1'b0;
                w_bready_nxt  = 1'b0;
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
            end
        endcase

        // Watchdog abort: release the bus and report a timed-out SLVERR.
        if (w_abort) begin
            w_state_nxt       = ST_IDLE;
            w_awvalid_nxt     = 1'b0;
            w_wvalid_nxt      = 1'b0;
            w_bready_nxt      = 1'b0;
            w_arvalid_nxt     = 1'b0;
            w_rready_nxt      = 1'b0;
            w_rsp_valid_nxt   = 1'b1;
            w_rsp_data_nxt    = '0;
            w_rsp_resp_nxt    = TRANS_WR_RESP_W'(RESP_SLVERR);
            w_rsp_timeout_nxt = 1'b1;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state       <= ST_IDLE;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_resp    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_awvalid     <= w_awvalid_nxt;
            r_wvalid      <= w_wvalid_nxt;
            r_aw_done     <= w_aw_done_nxt;
            r_w_done      <= w_w_done_nxt;
            r_bready      <= w_bready_nxt;
            r_arvalid     <= w_arvalid_nxt;
            r_rready      <= w_rready_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_wstrb       <= w_wstrb_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            r_rsp_resp    <= w_rsp_resp_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    assign o_axi_awaddr  = r_addr;
    assign o_axi_awprot  = TRANS_PROT'(PROT_DEFAULT);
    assign o_axi_awvalid = r_awvalid;
    assign o_axi_wdata   = r_wdata;
    assign o_axi_wstrb   = r_wstrb;
    assign o_axi_wvalid  = r_wvalid;
    assign o_axi_bready  = r_bready;
    assign o_axi_araddr  = r_addr;
    assign o_axi_arprot  = TRANS_PROT'(PROT_DEFAULT);
    assign o_axi_arvalid = r_arvalid;
    assign o_axi_rready  = r_rready;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_data_o    = r_rsp_data;
    assign rsp_resp_o    = r_rsp_resp;
    assign rsp_timeout_o = r_rsp_timeout;

endmodule : axi_lite_master_sequencer

// File: tb/tb_axi_lite_master_sequencer.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master_sequencer
// Self-checking bench: a behavioural slave with per-channel ready/valid delays,
// and a reference model that predicts response latency, data, resp code,
// timeout flag and per-channel handshake counts from those delays.
// -----------------------------------------------------------------------------
module tb_axi_lite_master_sequencer;

    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        resetn_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic [3:0]  cmd_wstrb_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_resp_o;
    logic        rsp_timeout_o;
    logic [31:0] o_axi_awaddr;
    logic [2:0]  o_axi_awprot;
    logic        o_axi_awvalid;
    logic        i_axi_awready = 1'b0;
    logic [31:0] o_axi_wdata;
    logic [3:0]  o_axi_wstrb;
    logic        o_axi_wvalid;
    logic        i_axi_wready = 1'b0;
    logic [1:0]  i_axi_bresp = '0;
    logic        i_axi_bvalid = 1'b0;
    logic        o_axi_bready;
    logic [31:0] o_axi_araddr;
    logic [2:0]  o_axi_arprot;
    logic        o_axi_arvalid;
    logic        i_axi_arready = 1'b0;
    logic [31:0] i_axi_rdata = '0;
    logic [1:0]  i_axi_rresp = '0;
    logic        i_axi_rvalid = 1'b0;
    logic        o_axi_rready;

    int n_vec = 0;
    int n_err = 0;

    // slave configuration and bookkeeping
    int s_aw_dly = 0, s_w_dly = 0, s_b_dly = 0, s_ar_dly = 0, s_r_dly = 0;
    int s_aw_cnt = 0, s_w_cnt = 0, s_b_cnt = 0, s_ar_cnt = 0, s_r_cnt = 0;
    int n_aw = 0, n_w = 0, n_ar = 0;
    bit hs_aw = 0, hs_w = 0, hs_ar = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;

    axi_lite_master_sequencer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TRANS_W_STRB_W(4),
        .TRANS_WR_RESP_W(2), .TRANS_PROT(3), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_addr_i(cmd_addr_i),
        .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .rsp_resp_o(rsp_resp_o), .rsp_timeout_o(rsp_timeout_o),
        .o_axi_awaddr(o_axi_awaddr), .o_axi_awprot(o_axi_awprot),
        .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
        .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
        .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready),
        .i_axi_bresp(i_axi_bresp), .i_axi_bvalid(i_axi_bvalid),
        .o_axi_bready(o_axi_bready),
        .o_axi_araddr(o_axi_araddr), .o_axi_arprot(o_axi_arprot),
        .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
        .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp),
        .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Record handshakes and captured payload on each active edge.
    always @(posedge clk_i) begin
        hs_aw = o_axi_awvalid && i_axi_awready;
        hs_w  = o_axi_wvalid && i_axi_wready;
        hs_ar = o_axi_arvalid && i_axi_arready;
        if (hs_aw) begin n_aw++; cap_awaddr = o_axi_awaddr; end
        if (hs_w)  begin n_w++;  cap_wdata = o_axi_wdata; cap_wstrb = o_axi_wstrb; end
        if (hs_ar) begin n_ar++; cap_araddr = o_axi_araddr; end
    end

    // Slave: each ready/valid rises after the master signal has been seen for dly+1 cycles.
    always @(negedge clk_i) begin
        if (hs_aw) check_eq("awvalid_drop", 64'(o_axi_awvalid), 64'(0));
        if (hs_w)  check_eq("wvalid_drop", 64'(o_axi_wvalid), 64'(0));
        if (hs_ar) check_eq("arvalid_drop", 64'(o_axi_arvalid), 64'(0));
        hs_aw = 0; hs_w = 0; hs_ar = 0;
        s_aw_cnt = o_axi_awvalid ? s_aw_cnt + 1 : 0;
        s_w_cnt  = o_axi_wvalid  ? s_w_cnt + 1  : 0;
        s_b_cnt  = o_axi_bready  ? s_b_cnt + 1  : 0;
        s_ar_cnt = o_axi_arvalid ? s_ar_cnt + 1 : 0;
        s_r_cnt  = o_axi_rready  ? s_r_cnt + 1  : 0;
        i_axi_awready = o_axi_awvalid && (s_aw_cnt > s_aw_dly);
        i_axi_wready  = o_axi_wvalid  && (s_w_cnt > s_w_dly);
        i_axi_bvalid  = o_axi_bready  && (s_b_cnt > s_b_dly);
        i_axi_arready = o_axi_arvalid && (s_ar_cnt > s_ar_dly);
        i_axi_rvalid  = o_axi_rready  && (s_r_cnt > s_r_dly);
    end

    // One transaction: d0/d1/d2 = aw/w/b delays for writes, ar/r delays for reads.
    // Called and returns at a falling edge; hold keeps cmd_valid high while busy.
    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input int d0, input int d1, input int d2,
                          input logic [31:0] rd, input logic [1:0] code,
                          input bit hold, input bit poke);
        int  fin, lat, k;
        bit  tmo, got;
        // completion edge relative to the accept edge
        fin = we ? (2 + ((d0 > d1) ? d0 : d1) + d2) : (2 + d0 + d1);
        tmo = (fin > TMO);
        lat = tmo ? TMO : fin;
        if (we) begin
            s_aw_dly = d0; s_w_dly = d1; s_b_dly = d2; i_axi_bresp = code;
        end else begin
            s_ar_dly = d0; s_r_dly = d1; i_axi_rdata = rd; i_axi_rresp = code;
        end
        n_aw = 0; n_w = 0; n_ar = 0;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr;
        cmd_wdata_i = wd; cmd_wstrb_i = st;
        check_eq("cmd_ready", 64'(cmd_ready_o), 64'(1));
        @(posedge clk_i);
        #1 cmd_valid_i = hold;
        k = 0; got = 0;
        while (!got && k < 40) begin
            @(negedge clk_i);
            k++;
            if (poke && k == 2) begin
                cmd_valid_i = 1'b1; cmd_we_i = ~we;
            end else if (poke && k == 3) begin
                cmd_valid_i = 1'b0;
            end
            if (rsp_valid_o) got = 1;
        end
        check_eq("rsp_latency", 64'(k), 64'(lat + 1));
        check_eq("rsp_timeout", 64'(rsp_timeout_o), 64'(tmo));
        check_eq("rsp_data", 64'(rsp_data_o), (we || tmo) ? 64'(0) : 64'(rd));
        check_eq("rsp_resp", 64'(rsp_resp_o), tmo ? 64'(2'b10) : 64'(code));
        check_eq("rsp_cycle_ready", 64'(cmd_ready_o), 64'(1));
        check_eq("rsp_cycle_bus_idle",
                 64'({o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready}),
                 64'(0));
        check_eq("aw_hs_count", 64'(n_aw), 64'(we && (d0 + 1 <= TMO)));
        check_eq("w_hs_count", 64'(n_w), 64'(we && (d1 + 1 <= TMO)));
        check_eq("ar_hs_count", 64'(n_ar), 64'(!we && (d0 + 1 <= TMO)));
        if (n_aw == 1) check_eq("slave_awaddr", 64'(cap_awaddr), 64'(addr));
        if (n_w == 1) begin
            check_eq("slave_wdata", 64'(cap_wdata), 64'(wd));
            check_eq("slave_wstrb", 64'(cap_wstrb), 64'(st));
        end
        if (n_ar == 1) check_eq("slave_araddr", 64'(cap_araddr), 64'(addr));
    endtask

    task automatic idle_chk();
        @(negedge clk_i);
        check_eq("rsp_single_pulse", 64'(rsp_valid_o), 64'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check_eq("reset_cmd_ready", 64'(cmd_ready_o), 64'(1));
        check_eq("reset_ctrl",
                 64'({o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid,
                      o_axi_rready, rsp_valid_o, rsp_timeout_o}), 64'(0));
        check_eq("reset_addr", 64'(o_axi_awaddr), 64'(0));
        check_eq("reset_wdata", 64'(o_axi_wdata), 64'(0));
        check_eq("reset_rsp", 64'({rsp_data_o, rsp_resp_o}), 64'(0));
        check_eq("prot", 64'({o_axi_awprot, o_axi_arprot}), 64'(0));
        resetn_i = 1'b1;
        @(negedge clk_i);

        // basic write and read
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 3, 3, 32'h0, 2'b00, 1'b0, 1'b0); idle_chk();
        do_txn(1'b0, 32'h20, 32'h0, 4'h0, 1, 2, 0, 32'h12345678, 2'b00, 1'b0, 1'b0); idle_chk();
        // AW/W ordering: AW first, W first, same edge
        do_txn(1'b1, 32'h24, 32'hA5A5_0001, 4'h3, 0, 2, 1, 32'h0, 2'b10, 1'b0, 1'b0); idle_chk();
        do_txn(1'b1, 32'h28, 32'hA5A5_0002, 4'hC, 2, 0, 0, 32'h0, 2'b00, 1'b0, 1'b0); idle_chk();
        do_txn(1'b1, 32'h2C, 32'hA5A5_0003, 4'h5, 1, 1, 2, 32'h0, 2'b00, 1'b0, 1'b0); idle_chk();
        // hung AW -> timeout, then a normal read
        do_txn(1'b1, 32'h30, 32'h0BAD_0BAD, 4'hF, 255, 0, 0, 32'h0, 2'b00, 1'b0, 1'b0); idle_chk();
        do_txn(1'b0, 32'h34, 32'h0, 4'h0, 0, 0, 0, 32'hCAFE_F00D, 2'b00, 1'b0, 1'b0); idle_chk();
        // watchdog boundary: completion exactly at the limit wins, one more times out
        do_txn(1'b0, 32'h38, 32'h0, 4'h0, 7, 7, 0, 32'h1111_2222, 2'b00, 1'b0, 1'b0); idle_chk();
        do_txn(1'b0, 32'h3C, 32'h0, 4'h0, 7, 8, 0, 32'h3333_4444, 2'b00, 1'b0, 1'b0); idle_chk();
        do_txn(1'b1, 32'h40, 32'h5555_6666, 4'h9, 6, 3, 8, 32'h0, 2'b10, 1'b0, 1'b0); idle_chk();
        // back-to-back with cmd_valid held; then a busy-time command pulse on a read
        do_txn(1'b1, 32'h44, 32'h7777_8888, 4'hF, 1, 0, 1, 32'h0, 2'b00, 1'b1, 1'b0);
        do_txn(1'b0, 32'h48, 32'h0, 4'h0, 0, 1, 0, 32'h9999_AAAA, 2'b10, 1'b0, 1'b0); idle_chk();
        do_txn(1'b0, 32'h4C, 32'h0, 4'h0, 2, 3, 0, 32'hBBBB_CCCC, 2'b00, 1'b0, 1'b1); idle_chk();

        // reset while waiting in the read-response phase
        s_ar_dly = 0; s_r_dly = 255;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h50;
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check_eq("rd_resp_rready", 64'(o_axi_rready), 64'(1));
        resetn_i = 1'b0;
        #1;
        check_eq("rst_mid_bus", 64'({o_axi_arvalid, o_axi_rready}), 64'(0));
        check_eq("rst_mid_ready", 64'(cmd_ready_o), 64'(1));
        repeat (2) begin
            @(negedge clk_i);
            check_eq("rst_mid_no_rsp", 64'(rsp_valid_o), 64'(0));
        end
        resetn_i = 1'b1;
        @(negedge clk_i);
        check_eq("after_rst_no_rsp", 64'(rsp_valid_o), 64'(0));

        // randomized traffic, occasionally hanging one channel
        for (int i = 0; i < 40; i++) begin
            bit          we, hold;
            int          d0, d1, d2;
            logic [1:0]  code;
            we   = ($urandom_range(0, 1) == 1);
            hold = (i != 39) && ($urandom_range(0, 3) == 0);
            d0   = $urandom_range(0, 8);
            d1   = $urandom_range(0, 8);
            d2   = $urandom_range(0, 8);
            case ($urandom_range(0, 9))
                0: d0 = 255;
                1: d1 = 255;
                2: d2 = 255;
                default: d0 = d0;
            endcase
            code = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
            do_txn(we, $urandom, $urandom, 4'($urandom_range(0, 15)), d0, d1, d2,
                   $urandom, code, hold, 1'b0);
            if (!hold) idle_chk();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_axi_lite_master_sequencer
